// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: address map, region select value and default sizes shared by mem_bus_responder
package mem_bus_pkg;
  localparam int DEF_RAM_ADDR_WIDTH = 17;
  localparam int DEF_TX_FIFO_DEPTH = 8;
  localparam logic [1:0] IO_REGION_SEL = 2'b11;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;
  typedef enum logic [1:0] {SEL_RAM, SEL_DATA, SEL_CTRL, SEL_NONE} bus_sel_e;
  // SEL_CTRL covers the 4-byte window at IO_CTRL_ADDR (halt on write, cycle counter on read)
  function automatic bus_sel_e decode_addr(input logic [17:0] a);
    return a[17:16] != IO_REGION_SEL ? SEL_RAM :
           a == IO_DATA_ADDR ? SEL_DATA :
           a[17:2] == IO_CTRL_ADDR[17:2] ? SEL_CTRL : SEL_NONE;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-2 deep byte queue with count, full and almost-full flags
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [7:0]             i_din,
  input  logic                   i_pop,
  output logic [7:0]             o_dout,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_pop = i_pop && r_count != '0;
  assign w_push = i_push && (r_count != (AW+1)'(DEPTH) || w_pop);
  assign o_dout = r_mem[r_rp];
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_almost_full = r_count >= (AW+1)'(DEPTH - 1);
  // pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // storage is not reset; only entries between the pointers are ever visible
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: CPU byte bus to RAM plus UART/halt I/O; MEM_BUS_RESPONDER_CLK_COUNTER_EN adds a readable cycle counter
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int TX_FIFO_DEPTH = DEF_TX_FIFO_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        program_done,
  output logic        tx_overflow
);
  logic [7:0] r_ram [2**RAM_ADDR_WIDTH];
  logic [7:0] r_rdata;
  logic r_done, r_ovf;
  bus_sel_e w_sel;
  logic w_halt_wr, w_push, w_pop, w_full;
  logic [7:0] w_push_data, w_ctrl_rdata, w_io_rdata;
  logic [$clog2(TX_FIFO_DEPTH):0] w_count;
  logic w_unused;
  assign w_sel = decode_addr(mem_a[17:0]);
  assign w_halt_wr = mem_wr && !r_done && w_sel == SEL_CTRL && mem_a[1:0] == 2'b00;
  assign w_push = w_halt_wr || (mem_wr && !r_done && w_sel == SEL_DATA && mem_wdata != 8'h00);
  assign w_push_data = w_halt_wr ? 8'h00 : mem_wdata;
  assign w_pop = tx_valid && tx_ready;
  assign rx_pop = rst_in && !mem_wr && w_sel == SEL_DATA && rx_valid;
  assign w_io_rdata = w_sel == SEL_DATA ? (rx_valid ? rx_data : 8'h00) :
                      w_sel == SEL_CTRL ? w_ctrl_rdata : 8'h00;
  assign mem_rdata = r_rdata;
  assign program_done = r_done;
  assign tx_overflow = r_ovf;
  assign w_unused = ^{mem_a[31:18], w_count};
`ifdef MEM_BUS_RESPONDER_CLK_COUNTER_EN
  logic [31:0] r_cnt, r_snap;
  // free-running cycle counter; reading byte 0 freezes all four bytes for the following reads
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      r_cnt <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (!mem_wr && w_sel == SEL_CTRL && mem_a[1:0] == 2'b00) r_snap <= r_cnt;
    end
  assign w_ctrl_rdata = mem_a[1:0] == 2'b00 ? r_cnt[7:0] : r_snap[8*mem_a[1:0] +: 8];
`else
  assign w_ctrl_rdata = 8'h00;
`endif
  // RAM contents survive reset; writes stop once the program has halted
  always_ff @(posedge clk_in)
    if (mem_wr && !r_done && w_sel == SEL_RAM) r_ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata;
  // registered read data, sticky halt and sticky tx overflow
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      r_rdata <= 8'h00;
      r_done <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (!mem_wr) r_rdata <= w_sel == SEL_RAM ? r_ram[mem_a[RAM_ADDR_WIDTH-1:0]] : w_io_rdata;
      if (w_halt_wr) r_done <= 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .i_clk(clk_in),
    .i_rst_n(rst_in),
    .i_push(w_push),
    .i_din(w_push_data),
    .i_pop(w_pop),
    .o_dout(tx_data),
    .o_valid(tx_valid),
    .o_count(w_count),
    .o_full(w_full),
    .o_almost_full(io_buffer_full)
  );
endmodule
